// File: rtl/pool_stream_collector_pkg.sv
// Shared types and sizing for the pooled-stream collector: sample geometry,
// FIFO entry layout and the frame FSM states.
package pool_stream_collector_pkg;
   localparam int CH         = 5;
   localparam int DW         = 10;
   localparam int DEPTH      = 16;
   localparam int FRAME_LEN  = 64;
   localparam int SKIP_FIRST = 1;
   localparam int DATA_W     = CH * DW;
   localparam int ENTRY_W    = DATA_W + 1;
   localparam int LVL_W      = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SKIP,
      ST_COLLECT,
      ST_DONE
   } state_e;

   // last marker rides in the MSB so the head word decodes directly
   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } entry_t;
endpackage

// File: rtl/pool_stream_collector_if.sv
// Pool-side strobe stream in, valid/ready sample stream out, plus status.
interface pool_stream_collector_if;
   import pool_stream_collector_pkg::*;

   logic              frame_act;
   logic              in_val;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              frame_done;
   logic              overflow;
   logic [LVL_W-1:0]  level;

   modport slave (
      input  frame_act, in_val, in_data, out_ready,
      output out_valid, out_data, out_last, frame_done, overflow, level
   );

   modport master (
      output frame_act, in_val, in_data, out_ready,
      input  out_valid, out_data, out_last, frame_done, overflow, level
   );
endinterface

// File: rtl/pool_stream_collector_fifo.sv
// First-word-fall-through FIFO; head word is visible combinationally while
// not empty. Pointers carry an extra wrap bit to separate full from empty.
module sync_fifo_fwft #(
   parameter int WIDTH = 51,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_q, rd_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign level_o = wr_q - rd_q;
   assign rdata_o = mem_q[rd_q[AW-1:0]];

   // a pop in the same cycle frees the slot a full-FIFO push needs
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
   end
endmodule

// File: rtl/pool_stream_collector.sv
// Frame-aware collector: drops the leading bogus strobes of each frame,
// buffers FRAME_LEN samples and replays them with an end-of-frame marker.
module pool_stream_collector
   import pool_stream_collector_pkg::*;
#(
   parameter int FRAME_LEN  = pool_stream_collector_pkg::FRAME_LEN,
   parameter int SKIP_FIRST = pool_stream_collector_pkg::SKIP_FIRST
) (
   input logic                    clk,
   input logic                    rst,
   pool_stream_collector_if.slave bus
);
   localparam int SW  = $clog2(FRAME_LEN + 1);
   localparam int SKW = (SKIP_FIRST > 0) ? $clog2(SKIP_FIRST + 1) : 1;

   state_e          state_q;
   logic            fa_q;
   logic [SW-1:0]   samp_cnt_q;
   logic [SKW-1:0]  skip_cnt_q;
   logic [SKW-1:0]  skip_d;
   logic            overflow_q;
   logic            frame_done_q;
   logic            rise, push, pop, is_last;
   logic            full, empty;
   entry_t          wr_e, head_e;
   logic [LVL_W-1:0] level;

   assign rise    = bus.frame_act & ~fa_q;
   assign is_last = (samp_cnt_q == SW'(FRAME_LEN - 1));
   assign skip_d  = skip_cnt_q + 1'b1;
   assign push    = (state_q == ST_COLLECT) & bus.in_val & bus.frame_act;
   assign pop     = bus.out_valid & bus.out_ready;

   assign wr_e.last = is_last;
   assign wr_e.data = bus.in_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         fa_q         <= 1'b0;
         samp_cnt_q   <= '0;
         skip_cnt_q   <= '0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         fa_q         <= bus.frame_act;
         frame_done_q <= 1'b0;
         if (!bus.frame_act) begin
            state_q <= ST_IDLE;
         end else if (rise) begin
            state_q    <= (SKIP_FIRST == 0) ? ST_COLLECT : ST_SKIP;
            samp_cnt_q <= '0;
            skip_cnt_q <= '0;
            overflow_q <= 1'b0;
         end else begin
            case (state_q)
               ST_SKIP: if (bus.in_val) begin
                  skip_cnt_q <= skip_d;
                  if (skip_d == SKW'(SKIP_FIRST)) state_q <= ST_COLLECT;
               end
               // dropped samples still advance samp_cnt to keep frame alignment
               ST_COLLECT: if (bus.in_val) begin
                  samp_cnt_q <= samp_cnt_q + 1'b1;
                  if (is_last) begin
                     state_q      <= ST_DONE;
                     frame_done_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
         if (push && full && !pop) overflow_q <= 1'b1;
      end
   end

   sync_fifo_fwft #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (wr_e),
      .pop_i   (pop),
      .rdata_o (head_e),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );

   // stale RAM contents never leak onto the bus while empty
   assign bus.out_valid  = ~empty;
   assign bus.out_data   = empty ? '0 : head_e.data;
   assign bus.out_last   = ~empty & head_e.last;
   assign bus.frame_done = frame_done_q;
   assign bus.overflow   = overflow_q;
   assign bus.level      = level;
endmodule

// File: tb/tb_pool_stream_collector.sv
// Randomized bench: a queue-based frame model is compared against the DUT
// every cycle, with literal expectations for the directed scenarios.
module tb_pool_stream_collector;
   import pool_stream_collector_pkg::*;

   localparam int SKIP = 1;
   localparam int FLEN = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pool_stream_collector_if ifa ();
   pool_stream_collector_if ifb ();

   pool_stream_collector #(.FRAME_LEN(FLEN), .SKIP_FIRST(SKIP)) dut_a (
      .clk (clk), .rst (rst), .bus (ifa.slave)
   );
   pool_stream_collector #(.FRAME_LEN(FLEN), .SKIP_FIRST(0)) dut_b (
      .clk (clk), .rst (rst), .bus (ifb.slave)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of dut_a ----------------
   entry_t m_q[$];
   int     m_pulses, m_idx;
   bit     m_active, m_fa, m_ovf, m_fd, m_pop, m_rise;
   entry_t m_e;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_pulses = 0; m_active = 0; m_fa = 0; m_ovf = 0; m_fd = 0;
      end else begin
         m_pop  = (m_q.size() > 0) && ifa.out_ready;
         m_rise = ifa.frame_act && !m_fa;
         m_fd   = 0;
         if (m_pop) void'(m_q.pop_front());
         if (m_rise) begin
            m_pulses = 0; m_ovf = 0; m_active = 1;
         end else if (ifa.frame_act && ifa.in_val && m_active) begin
            m_pulses++;
            if (m_pulses > SKIP) begin
               m_idx     = m_pulses - SKIP;
               m_e.last  = (m_idx == FLEN);
               m_e.data  = ifa.in_data;
               if (m_q.size() < DEPTH) m_q.push_back(m_e);
               else m_ovf = 1;
               if (m_idx == FLEN) begin m_active = 0; m_fd = 1; end
            end
         end
         if (!ifa.frame_act) m_active = 0;
         m_fa = ifa.frame_act;
      end
   end

   // ---------------- compare + transfer monitor ----------------
   int xfer_n = 0, last_n = 0, fd_n = 0;
   logic [DATA_W-1:0] got[$];
   bit                got_l[$];

   always @(negedge clk) begin
      if (!rst) begin
         chk("out_valid", ifa.out_valid, m_q.size() > 0);
         if (m_q.size() > 0) begin
            chk("out_data", ifa.out_data, m_q[0].data);
            chk("out_last", ifa.out_last, m_q[0].last);
         end
         chk("level", ifa.level, m_q.size());
         chk("overflow", ifa.overflow, m_ovf);
         chk("frame_done", ifa.frame_done, m_fd);
         if (ifa.out_valid && ifa.out_ready) begin
            xfer_n++;
            got.push_back(ifa.out_data);
            got_l.push_back(ifa.out_last);
            if (ifa.out_last) last_n++;
         end
         if (ifa.frame_done) fd_n++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   function automatic logic [DATA_W-1:0] rnd_d();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[DATA_W-1:0];
   endfunction

   task automatic pulse(input logic [DATA_W-1:0] d);
      ifa.in_val = 1'b1; ifa.in_data = d;
      step();
      ifa.in_val = 1'b0;
   endtask

   task automatic drain();
      int n;
      ifa.out_ready = 1'b1;
      n = 0;
      while ((ifa.out_valid || ifa.level != 0) && n < 300) begin step(); n++; end
      if (n >= 300) chk("drain_timeout", 1, 0);
      step();
   endtask

   logic [DATA_W-1:0] s[$], s2[$];
   logic [DATA_W-1:0] d;
   int bx, bl, bf, bg, n;

   task automatic snap();
      bx = xfer_n; bl = last_n; bf = fd_n; bg = got.size();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      ifa.frame_act = 0; ifa.in_val = 0; ifa.in_data = '0; ifa.out_ready = 0;
      ifb.frame_act = 0; ifb.in_val = 0; ifb.in_data = '0; ifb.out_ready = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      step();
      chk("rst_valid", ifa.out_valid, 0);
      chk("rst_level", ifa.level, 0);
      chk("rst_ovf", ifa.overflow, 0);
      chk("rst_fd", ifa.frame_done, 0);
      chk("rst_data", ifa.out_data, 0);

      // T1 nominal
      snap(); s.delete();
      ifa.out_ready = 1; ifa.frame_act = 1; step();
      for (int i = 0; i < 65; i++) begin d = rnd_d(); s.push_back(d); pulse(d); step(); end
      repeat (4) step();
      chk("t1_ovf", ifa.overflow, 0);
      ifa.frame_act = 0; step(); drain();
      chk("t1_words", xfer_n - bx, 64);
      chk("t1_lasts", last_n - bl, 1);
      chk("t1_fd", fd_n - bf, 1);
      chk("t1_first", got[bg], s[1]);
      chk("t1_word64", got[bg+63], s[64]);
      chk("t1_last64", got_l[bg+63], 1);

      // T2 full backpressure
      snap(); s.delete();
      ifa.out_ready = 0; ifa.frame_act = 1; step();
      for (int i = 0; i < 65; i++) begin d = rnd_d(); s.push_back(d); pulse(d); step(); end
      step();
      chk("t2_level", ifa.level, 16);
      chk("t2_ovf", ifa.overflow, 1);
      chk("t2_fd", fd_n - bf, 1);
      ifa.frame_act = 0; step(); drain();
      chk("t2_words", xfer_n - bx, 16);
      chk("t2_lasts", last_n - bl, 0);
      chk("t2_first", got[bg], s[1]);
      chk("t2_w16", got[bg+15], s[16]);

      // T3 push and pop together while full
      snap(); s.delete();
      ifa.out_ready = 0; ifa.frame_act = 1; step();
      for (int i = 0; i < 17; i++) begin d = rnd_d(); s.push_back(d); pulse(d); step(); end
      chk("t3_full", ifa.level, 16);
      d = rnd_d(); s.push_back(d);
      ifa.out_ready = 1; pulse(d); ifa.out_ready = 0;
      chk("t3_level", ifa.level, 16);
      chk("t3_ovf", ifa.overflow, 0);
      ifa.frame_act = 0; step(); drain();
      chk("t3_words", xfer_n - bx, 17);
      chk("t3_tail", got[bg+16], s[17]);

      // T4 short frame then restart
      snap(); s.delete(); s2.delete();
      ifa.out_ready = 0; ifa.frame_act = 1; step();
      for (int i = 0; i < 11; i++) begin d = rnd_d(); s.push_back(d); pulse(d); step(); end
      ifa.frame_act = 0; step();
      ifa.frame_act = 1; step();
      for (int i = 0; i < 3; i++) begin d = rnd_d(); s2.push_back(d); pulse(d); step(); end
      ifa.frame_act = 0; step(); drain();
      chk("t4_words", xfer_n - bx, 12);
      chk("t4_lasts", last_n - bl, 0);
      chk("t4_fd", fd_n - bf, 0);
      chk("t4_w10", got[bg+9], s[10]);
      chk("t4_w11", got[bg+10], s2[1]);

      // T5 async reset mid-collect
      ifa.out_ready = 0; ifa.frame_act = 1; step();
      for (int i = 0; i < 20; i++) begin pulse(rnd_d()); step(); end
      chk("t5_pre_ovf", ifa.overflow, 1);
      @(posedge clk); #3 rst = 1'b1;
      #1;
      chk("t5_valid", ifa.out_valid, 0);
      chk("t5_level", ifa.level, 0);
      chk("t5_ovf", ifa.overflow, 0);
      ifa.frame_act = 0;
      @(posedge clk); #1 rst = 1'b0;
      step();

      // T6 no skip, signed extremes, on the second instance
      d = rnd_d(); d[DW-1:0] = 10'h200; d[DATA_W-1 -: DW] = 10'h1FF;
      ifb.out_ready = 1; ifb.frame_act = 1; step();
      ifb.in_val = 1; ifb.in_data = d; step(); ifb.in_val = 0;
      n = 0;
      while (!ifb.out_valid && n < 5) begin step(); n++; end
      chk("t6_valid", ifb.out_valid, 1);
      chk("t6_level", ifb.level, 1);
      chk("t6_data", ifb.out_data, d);
      chk("t6_last", ifb.out_last, 0);
      ifb.frame_act = 0; step(); step();
      chk("t6_empty", ifb.level, 0);

      // T7 randomized frames: gaps, random ready, short and long frames
      for (int f = 0; f < 5; f++) begin
         int np, sent, rmode;
         np = $urandom_range(5, 75); sent = 0; rmode = $urandom_range(0, 2);
         ifa.frame_act = 1; ifa.in_val = $urandom_range(0, 1); ifa.in_data = rnd_d();
         ifa.out_ready = $urandom_range(0, 1);
         step();
         while (sent < np) begin
            ifa.in_val = ($urandom_range(0, 2) == 0);
            ifa.in_data = rnd_d();
            ifa.out_ready = (rmode == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            if (ifa.in_val) sent++;
            step();
         end
         ifa.frame_act = 0;
         for (int k = 0; k < 8; k++) begin
            ifa.in_val = $urandom_range(0, 1); ifa.in_data = rnd_d();
            ifa.out_ready = $urandom_range(0, 1);
            step();
         end
         ifa.in_val = 0;
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
